// File: rtl/pattern_history_table.sv
// Gshare-style pattern history table: 8 two-bit saturating counters indexed by ghr ^ pc[4:2],
// with one-cycle registered prediction, same-cycle update bypass and a saturating mispredict counter.
module pattern_history_table #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    input  logic [2:0]       ghr,
    output logic             predict_valid,
    output logic             predict_taken,
    output logic [2:0]       pred_index,
    input  logic             update_valid,
    input  logic [2:0]       update_index,
    input  logic             update_taken,
    input  logic             update_mispredict,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CTR_W   = 2;
    localparam logic [CTR_W-1:0] CTR_MIN = 2'b00;
    localparam logic [CTR_W-1:0] CTR_MAX = 2'b11;
    localparam logic [CTR_W-1:0] WEAK_NT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CTR_W-1:0] table_q [ENTRIES];
    logic [IDX_W-1:0] lookup_index_c;
    logic [CTR_W-1:0] upd_cur_c;
    logic [CTR_W-1:0] upd_next_c;
    logic [CTR_W-1:0] lookup_ctr_c;
    logic             unused_pc_bits;

    // Only pc[4:2] participates in indexing.
    assign unused_pc_bits = ^{lookup_pc[31:5], lookup_pc[1:0]};
    assign lookup_index_c = ghr ^ lookup_pc[4:2];

    // Saturating next value of the entry being updated.
    always_comb begin
        upd_cur_c  = table_q[update_index];
        upd_next_c = upd_cur_c;
        if (update_taken) begin
            if (upd_cur_c != CTR_MAX) upd_next_c = upd_cur_c + CTR_W'(1);
        end else begin
            if (upd_cur_c != CTR_MIN) upd_next_c = upd_cur_c - CTR_W'(1);
        end
    end

    // Write-before-read: a same-index update in this cycle is forwarded to the lookup.
    always_comb begin
        lookup_ctr_c = table_q[lookup_index_c];
        if (update_valid && (update_index == lookup_index_c)) lookup_ctr_c = upd_next_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) table_q[IDX_W'(i)] <= WEAK_NT;
        end else if (update_valid) begin
            table_q[update_index] <= upd_next_c;
        end
    end

    // Prediction register; taken/index hold when no lookup is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            predict_valid <= 1'b0;
            predict_taken <= 1'b0;
            pred_index    <= '0;
        end else begin
            predict_valid <= lookup_valid;
            if (lookup_valid) begin
                predict_taken <= lookup_ctr_c[CTR_W-1];
                pred_index    <= lookup_index_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_count <= '0;
        end else if (update_valid && update_mispredict && (mispredict_count != CNT_MAX)) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed bench for pattern_history_table: an integer-array reference model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_pattern_history_table;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             lookup_valid;
    logic [31:0]      lookup_pc;
    logic [2:0]       ghr;
    logic             predict_valid;
    logic             predict_taken;
    logic [2:0]       pred_index;
    logic             update_valid;
    logic [2:0]       update_index;
    logic             update_taken;
    logic             update_mispredict;
    logic [CNT_W-1:0] mispredict_count;

    pattern_history_table #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .ghr              (ghr),
        .predict_valid    (predict_valid),
        .predict_taken    (predict_taken),
        .pred_index       (pred_index),
        .update_valid     (update_valid),
        .update_index     (update_index),
        .update_taken     (update_taken),
        .update_mispredict(update_mispredict),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain integers 0..3.
    int ent [8];
    int m_pv, m_pt, m_pi, m_cnt;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ent[i] = 1;
        m_pv = 0; m_pt = 0; m_pi = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int idx;
        idx = int'(ghr) ^ int'(lookup_pc[4:2]);
        if (update_valid) begin
            if (update_taken) ent[update_index] = (ent[update_index] == 3) ? 3 : ent[update_index] + 1;
            else              ent[update_index] = (ent[update_index] == 0) ? 0 : ent[update_index] - 1;
            if (update_mispredict && m_cnt < CNT_SAT) m_cnt++;
        end
        if (lookup_valid) begin
            m_pv = 1;
            m_pi = idx;
            m_pt = (ent[idx] >= 2) ? 1 : 0;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic compare_all();
        check("model_pv",  32'(predict_valid),    32'(m_pv));
        check("model_pt",  32'(predict_taken),    32'(m_pt));
        check("model_pi",  32'(pred_index),       32'(m_pi));
        check("model_cnt", 32'(mispredict_count), 32'(m_cnt));
    endtask

    // One clock: drive inputs, advance model on the edge, compare 2 time units later.
    task automatic step(input bit lv, input logic [31:0] pc, input logic [2:0] g,
                        input bit uv, input logic [2:0] ui, input bit ut, input bit um);
        lookup_valid = lv; lookup_pc = pc; ghr = g;
        update_valid = uv; update_index = ui; update_taken = ut; update_mispredict = um;
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
    endtask

    task automatic idle();
        step(0, 32'h0, 3'd0, 0, 3'd0, 0, 0);
    endtask

    task automatic upd(input logic [2:0] ui, input bit ut);
        step(0, 32'h0, 3'd0, 1, ui, ut, 0);
    endtask

    task automatic look(input logic [31:0] pc, input logic [2:0] g);
        step(1, pc, g, 0, 3'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 0; lookup_pc = '0; ghr = '0;
        update_valid = 0; update_index = '0; update_taken = 0; update_mispredict = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        compare_all();
        check("rst_pv", 32'(predict_valid), 32'd0);
        check("rst_cnt", 32'(mispredict_count), 32'd0);
        reset = 1'b1;

        // Basic lookup from reset: entry 0 is weak-NT.
        look(32'h0000_0000, 3'b000);
        check("r030_pv", 32'(predict_valid), 32'd1);
        check("r030_pt", 32'(predict_taken), 32'd0);
        check("r030_pi", 32'(pred_index), 32'd0);
        idle();
        check("hold_pv", 32'(predict_valid), 32'd0);

        // Entry 5 saturates at strong-T.
        upd(3'd5, 1); upd(3'd5, 1); upd(3'd5, 1);
        look(32'h0000_0014, 3'b000);
        check("r031_pt", 32'(predict_taken), 32'd1);
        check("r031_pi", 32'(pred_index), 32'd5);
        upd(3'd5, 1);
        upd(3'd5, 0);
        look(32'h0000_0014, 3'b000);
        check("r031_sat_pt", 32'(predict_taken), 32'd1);
        upd(3'd5, 0);
        look(32'h0000_0014, 3'b000);
        check("r031_wnt_pt", 32'(predict_taken), 32'd0);

        // Entry 2 saturates at strong-NT.
        upd(3'd2, 0); upd(3'd2, 0); upd(3'd2, 0); upd(3'd2, 1);
        look(32'h0000_0008, 3'b000);
        check("r032_pt", 32'(predict_taken), 32'd0);
        check("r032_pi", 32'(pred_index), 32'd2);
        upd(3'd2, 1);
        look(32'h0000_0008, 3'b000);
        check("r032_wt_pt", 32'(predict_taken), 32'd1);

        // Same-cycle lookup and update on entry 3: bypass.
        step(1, 32'h0000_000C, 3'b000, 1, 3'd3, 1, 0);
        check("r033_pt", 32'(predict_taken), 32'd1);
        look(32'h0000_000C, 3'b000);
        check("r033_after_pt", 32'(predict_taken), 32'd1);

        // Different indices in the same cycle proceed independently.
        step(1, 32'h0000_0010, 3'b000, 1, 3'd1, 1, 0);
        check("r022_pt", 32'(predict_taken), 32'd0);
        check("r022_pi", 32'(pred_index), 32'd4);
        look(32'h0000_0004, 3'b000);
        check("r022_e1_pt", 32'(predict_taken), 32'd1);

        // GHR xor: pc[4:2]=110 ^ 011 -> 5 (entry 5 now weak-NT), then hold on idle.
        look(32'hFFFF_FFF8, 3'b011);
        check("xor_pi", 32'(pred_index), 32'd5);
        check("xor_pt", 32'(predict_taken), 32'd0);
        idle();
        check("hold_pi", 32'(pred_index), 32'd5);

        // Mispredict flag without update_valid is ignored.
        step(0, 32'h0, 3'd0, 0, 3'd7, 1, 1);
        check("r024_nouv", 32'(mispredict_count), 32'd0);

        // Saturating mispredict counter.
        for (int i = 1; i <= 17; i++) begin
            step(0, 32'h0, 3'd0, 1, 3'd7, 1, 1);
            if (i == 1)  check("r034_c1",  32'(mispredict_count), 32'd1);
            if (i == 15) check("r034_c15", 32'(mispredict_count), 32'd15);
        end
        check("r034_c17", 32'(mispredict_count), 32'd15);
        look(32'h0000_001C, 3'b000);
        check("r026_e7_pt", 32'(predict_taken), 32'd1);

        // Reset pulsed in the same cycle as an update to entry 6.
        look(32'h0000_0018, 3'b000);
        lookup_valid = 1; lookup_pc = 32'h0000_0018; ghr = 3'd0;
        update_valid = 1; update_index = 3'd6; update_taken = 1; update_mispredict = 1;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #2;
        compare_all();
        check("r035_pv", 32'(predict_valid), 32'd0);
        check("r035_cnt", 32'(mispredict_count), 32'd0);
        reset = 1'b1;
        idle();
        look(32'h0000_0018, 3'b000);
        check("r035_e6_pt", 32'(predict_taken), 32'd0);
        upd(3'd6, 1);
        look(32'h0000_0018, 3'b000);
        check("r035_e6_wt", 32'(predict_taken), 32'd1);
        look(32'h0000_000C, 3'b000);
        check("r035_e3_pt", 32'(predict_taken), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
